// File: rtl/y86_fetch.sv
// Byte-serial Y86 instruction fetch: assembles icode/ifun, rA/rB, valC and valP for decode.
// Define FETCH_COUNT_EN to add the InstrCount output (instructions handed to decode).
module y86_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        MemRead,
    output logic [31:0] MemAddr,
    input  logic [7:0]  MemData,
    input  logic        MemValid,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [3:0]  Icode,
    output logic [3:0]  Ifun,
    output logic [3:0]  Ra,
    output logic [3:0]  Rb,
    output logic [31:0] ValC,
    output logic [31:0] ValP,
    output logic [31:0] InstrPC,
    output logic        ErrInvalid,
    output logic        Halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] InstrCount
`endif
);

    typedef enum logic [2:0] {S_OP, S_REG, S_CONST, S_OUT, S_STOP} state_t;

    state_t      state, state_next;
    logic [1:0]  byte_idx, byte_idx_next;
    logic [31:0] fetch_pc;
    logic        take;
    logic        transfer;
    logic [3:0]  op_hi;

    function automatic logic has_reg(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic const_after_reg(input logic [3:0] ic);
        return (ic == 4'h3) || (ic == 4'h4) || (ic == 4'h5);
    endfunction

    function automatic logic const_direct(input logic [3:0] ic);
        return (ic == 4'h7) || (ic == 4'h8);
    endfunction

    // Invalid opcodes fall into the default and count as one byte.
    function automatic logic [31:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: return 32'd2;
            4'h7, 4'h8:             return 32'd5;
            4'h3, 4'h4, 4'h5:       return 32'd6;
            default:                return 32'd1;
        endcase
    endfunction

    assign op_hi      = MemData[7:4];
    assign MemAddr    = fetch_pc;
    assign InstrValid = (state == S_OUT);
    assign Halted     = (state == S_STOP);
    assign take       = MemRead & MemValid;
    assign transfer   = InstrValid & InstrReady;

    always_comb begin
        state_next    = state;
        byte_idx_next = byte_idx;
        MemRead       = 1'b0;
        case (state)
            S_OP: begin
                MemRead = 1'b1;
                if (MemValid) begin
                    if (op_hi > 4'hB)               state_next = S_OUT;
                    else if (has_reg(op_hi))        state_next = S_REG;
                    else if (const_direct(op_hi)) begin
                        state_next    = S_CONST;
                        byte_idx_next = 2'd0;
                    end
                    else                            state_next = S_OUT;
                end
            end
            S_REG: begin
                MemRead = 1'b1;
                if (MemValid) begin
                    byte_idx_next = 2'd0;
                    state_next    = const_after_reg(Icode) ? S_CONST : S_OUT;
                end
            end
            S_CONST: begin
                MemRead = 1'b1;
                if (MemValid) begin
                    if (byte_idx == 2'd3) state_next    = S_OUT;
                    else                  byte_idx_next = byte_idx + 2'd1;
                end
            end
            S_OUT: begin
                if (transfer)
                    state_next = ((Icode == 4'h0) || ErrInvalid) ? S_STOP : S_OP;
            end
            S_STOP: ;
            default: state_next = S_OP;
        endcase
        if (Redirect)
            state_next = S_OP;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_OP;
            byte_idx <= 2'd0;
        end else begin
            state    <= state_next;
            byte_idx <= byte_idx_next;
        end
    end

    // Fields are cleared at the opcode byte so absent register/constant bytes read as F/0.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetch_pc   <= RESET_PC;
            Icode      <= '0;
            Ifun       <= '0;
            Ra         <= '1;
            Rb         <= '1;
            ValC       <= '0;
            ValP       <= '0;
            InstrPC    <= '0;
            ErrInvalid <= 1'b0;
        end else if (Redirect) begin
            fetch_pc   <= RedirectPC;
            ValC       <= '0;
            ErrInvalid <= 1'b0;
        end else begin
            if (take)
                fetch_pc <= fetch_pc + 32'd1;
            if (transfer)
                fetch_pc <= ValP;
            if (take && state == S_OP) begin
                Icode      <= MemData[7:4];
                Ifun       <= MemData[3:0];
                InstrPC    <= fetch_pc;
                Ra         <= '1;
                Rb         <= '1;
                ValC       <= '0;
                ValP       <= fetch_pc + instr_len(op_hi);
                ErrInvalid <= (op_hi > 4'hB);
            end
            if (take && state == S_REG) begin
                Ra <= MemData[7:4];
                Rb <= MemData[3:0];
            end
            if (take && state == S_CONST)
                ValC[{byte_idx, 3'b000} +: 8] <= MemData;
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset)         InstrCount <= '0;
        else if (transfer) InstrCount <= InstrCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_y86_fetch.sv
// Bench for y86_fetch: directed sequences, a vector table and a random program checked against an
// instruction-level model. Build with +define+FETCH_COUNT_EN to also check InstrCount.
module tb_y86_fetch;

    logic        Clock;
    logic        Reset;
    logic        MemRead;
    logic [31:0] MemAddr;
    logic [7:0]  MemData;
    logic        MemValid;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [3:0]  Icode, Ifun, Ra, Rb;
    logic [31:0] ValC, ValP, InstrPC;
    logic        ErrInvalid;
    logic        Halted;

    logic        w_read;
    logic [31:0] w_addr;
    logic [7:0]  w_data;
    logic        w_redirect;
    logic [31:0] w_rpc;
    logic        w_ivalid;
    logic [3:0]  w_icode, w_ifun, w_ra, w_rb;
    logic [31:0] w_valc, w_valp, w_ipc;
    logic        w_err;
    logic        w_halt;

`ifdef FETCH_COUNT_EN
    logic [31:0] InstrCount;
    logic [31:0] w_count;
`endif

    y86_fetch #(.RESET_PC(32'h0)) dut (
        .Clock(Clock), .Reset(Reset),
        .MemRead(MemRead), .MemAddr(MemAddr), .MemData(MemData), .MemValid(MemValid),
        .Redirect(Redirect), .RedirectPC(RedirectPC),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Icode(Icode), .Ifun(Ifun), .Ra(Ra), .Rb(Rb),
        .ValC(ValC), .ValP(ValP), .InstrPC(InstrPC),
        .ErrInvalid(ErrInvalid), .Halted(Halted)
`ifdef FETCH_COUNT_EN
        , .InstrCount(InstrCount)
`endif
    );

    y86_fetch #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
        .Clock(Clock), .Reset(Reset),
        .MemRead(w_read), .MemAddr(w_addr), .MemData(w_data), .MemValid(MemValid),
        .Redirect(w_redirect), .RedirectPC(w_rpc),
        .InstrValid(w_ivalid), .InstrReady(InstrReady),
        .Icode(w_icode), .Ifun(w_ifun), .Ra(w_ra), .Rb(w_rb),
        .ValC(w_valc), .ValP(w_valp), .InstrPC(w_ipc),
        .ErrInvalid(w_err), .Halted(w_halt)
`ifdef FETCH_COUNT_EN
        , .InstrCount(w_count)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [47:0] bytes;
        int unsigned len;
        logic [3:0]  icode, ifun, ra, rb;
        logic [31:0] valc;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [31:0] valc, pc, valp;
    } instr_t;

    logic [7:0] mem [bit [31:0]];
    vec_t       vec [16];
    instr_t     exp_q [$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned mv_mode  = 0;   // 0: MemValid high, 1: toggling, 2: random

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    task automatic put(input logic [31:0] addr, input logic [47:0] b, input int unsigned len);
        for (int unsigned i = 0; i < len; i++)
            mem[addr + i] = b[8*i +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
        MemData = rd(MemAddr);
        w_data  = rd(w_addr);
        case (mv_mode)
            0:       MemValid = 1'b1;
            1:       MemValid = ~MemValid;
            default: MemValid = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic wait_valid(input string tag, output int unsigned n);
        n = 0;
        while (!InstrValid && n < 200) begin
            step();
            n++;
        end
        check({tag, "_valid_seen"}, 32'(InstrValid), 1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        Redirect   = 1'b1;
        RedirectPC = pc;
        step();
        Redirect   = 1'b0;
    endtask

    task automatic check_instr(input string tag, input logic [3:0] ic, input logic [3:0] ifn,
                               input logic [3:0] ra, input logic [3:0] rb, input logic [31:0] vc,
                               input logic [31:0] vp, input logic [31:0] pc);
        check({tag, "_valid"},   32'(InstrValid), 1);
        check({tag, "_icode"},   32'(Icode), 32'(ic));
        check({tag, "_ifun"},    32'(Ifun), 32'(ifn));
        check({tag, "_ra"},      32'(Ra), 32'(ra));
        check({tag, "_rb"},      32'(Rb), 32'(rb));
        check({tag, "_valc"},    ValC, vc);
        check({tag, "_valp"},    ValP, vp);
        check({tag, "_instrpc"}, InstrPC, pc);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_memread"}, 32'(MemRead), 1);
        check({tag, "_memaddr"}, MemAddr, 32'h0);
        check({tag, "_valid"},   32'(InstrValid), 0);
        check({tag, "_halted"},  32'(Halted), 0);
        check({tag, "_err"},     32'(ErrInvalid), 0);
        check({tag, "_icode"},   32'(Icode), 0);
        check({tag, "_ifun"},    32'(Ifun), 0);
        check({tag, "_ra"},      32'(Ra), 32'hF);
        check({tag, "_rb"},      32'(Rb), 32'hF);
        check({tag, "_valc"},    ValC, 0);
        check({tag, "_valp"},    ValP, 0);
        check({tag, "_instrpc"}, InstrPC, 0);
        check({tag, "_wrap_addr"}, w_addr, 32'hFFFF_FFFF);
`ifdef FETCH_COUNT_EN
        check({tag, "_count"},   InstrCount, 0);
`endif
    endtask

    // Random program generator: fields are chosen first, bytes are their encoding.
    task automatic build_random(input logic [31:0] base, input int unsigned count);
        logic [31:0] pc;
        pc = base;
        for (int unsigned i = 0; i < count; i++) begin
            instr_t      e;
            logic [3:0]  ic, ifn, ra, rb;
            logic [31:0] vc;
            bit          rg, cs;
            int unsigned len;
            ic  = 4'($urandom_range(1, 11));
            ifn = 4'($urandom_range(0, 15));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            vc  = $urandom;
            rg  = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
            cs  = ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
            len = 1 + (rg ? 1 : 0) + (cs ? 4 : 0);
            mem[pc] = {ic, ifn};
            if (rg) mem[pc + 1] = {ra, rb};
            if (cs)
                for (int unsigned k = 0; k < 4; k++)
                    mem[pc + (rg ? 2 : 1) + k] = vc[8*k +: 8];
            e.icode = ic;
            e.ifun  = ifn;
            e.ra    = rg ? ra : 4'hF;
            e.rb    = rg ? rb : 4'hF;
            e.valc  = cs ? vc : 32'h0;
            e.pc    = pc;
            e.valp  = pc + len;
            pc      = e.valp;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        int unsigned n;
        logic [31:0] cnt0;
        logic [31:0] base;
        int unsigned cyc;
        int unsigned ntr;

        cnt0 = 0;
        Reset = 1'b1; MemValid = 1'b1; MemData = 8'h00; Redirect = 1'b0; RedirectPC = 0;
        InstrReady = 1'b1; w_redirect = 1'b0; w_rpc = 0; w_data = 8'h00;

        put(32'h0,         48'h12345678F030, 6);   // irmovl $0x12345678, %eax
        put(32'h6,         48'h0160, 2);           // addl %eax, %ecx
        put(32'h8,         48'h00, 1);             // halt
        put(32'hFFFF_FFFF, 48'h60, 1);             // first byte of a wrapping addl
        put(32'h10,        48'h0000010074, 5);     // jne 0x100
        put(32'h15,        48'hC0, 1);             // invalid
        put(32'h20,        48'h000000081240, 6);   // rmmovl (aborted)
        put(32'h40,        48'h010203046750, 6);   // mrmovl 0x01020304(%edi), %esi
        put(32'h60,        48'h4520, 2);           // rrmovl %esp, %ebp

        step(); step();
        Reset = 1'b0;
        check_reset("reset");

        // irmovl from RESET_PC; the wrap instance fetches its 2-byte instruction meanwhile.
        for (int unsigned i = 1; i <= 6; i++) begin
            step();
            if (i == 1) check("wrap_second_addr", w_addr, 32'h0);
            if (i == 2) begin
                check("wrap_valid", 32'(w_ivalid), 1);
                check("wrap_icode", 32'(w_icode), 6);
                check("wrap_ra",    32'(w_ra), 3);
                check("wrap_rb",    32'(w_rb), 0);
                check("wrap_valp",  w_valp, 32'h1);
                check("wrap_pc",    w_ipc, 32'hFFFF_FFFF);
            end
            if (i == 5) check("irmovl_not_early", 32'(InstrValid), 0);
        end
        check_instr("irmovl", 4'h3, 4'h0, 4'hF, 4'h0, 32'h12345678, 32'h6, 32'h0);
        check("irmovl_memread_held", 32'(MemRead), 0);
        step();
        check("next_addr", MemAddr, 32'h6);
        check("next_memread", 32'(MemRead), 1);

        // Back-to-back addl then halt.
        step(); step();
        check_instr("addl", 4'h6, 4'h0, 4'h0, 4'h1, 32'h0, 32'h8, 32'h6);
        step();
        check("halt_addr", MemAddr, 32'h8);
        step();
        check_instr("halt", 4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h9, 32'h8);
        step();
        check("halted", 32'(Halted), 1);
        check("halted_valid", 32'(InstrValid), 0);
        step(); step();
        check("halted_memread", 32'(MemRead), 0);
        check("halted_stays", 32'(Halted), 1);
`ifdef FETCH_COUNT_EN
        check("count_after_halt", InstrCount, 32'd3);
`endif

        // jne with toggling MemValid and decode backpressure.
        redirect_to(32'h10);
        check("redir_unhalt", 32'(Halted), 0);
        check("redir_addr", MemAddr, 32'h10);
        mv_mode = 1;
        InstrReady = 1'b0;
        wait_valid("jne", n);
        for (int unsigned i = 0; i < 5; i++) begin
            check_instr("jne_hold", 4'h7, 4'h4, 4'hF, 4'hF, 32'h100, 32'h15, 32'h10);
            check("jne_hold_memread", 32'(MemRead), 0);
            step();
        end
        mv_mode = 0;
        InstrReady = 1'b1;
        step();
        check("jne_next_addr", MemAddr, 32'h15);

        // Invalid opcode, then redirect out of the stop state.
        wait_valid("inv", n);
        check("inv_cycles", n, 1);
        check("inv_err", 32'(ErrInvalid), 1);
        check("inv_icode", 32'(Icode), 32'hC);
        check("inv_valp", ValP, 32'h16);
        check("inv_pc", InstrPC, 32'h15);
        step();
        check("inv_halted", 32'(Halted), 1);
        check("inv_memread", 32'(MemRead), 0);
        redirect_to(32'h20);
        check("inv_redir_halted", 32'(Halted), 0);
        check("inv_redir_err", 32'(ErrInvalid), 0);
        check("inv_redir_addr", MemAddr, 32'h20);
        check("inv_redir_memread", 32'(MemRead), 1);

        // Abort an rmmovl at its third byte.
        step(); step();
        check("abort_third_addr", MemAddr, 32'h22);
        redirect_to(32'h40);
        check("abort_addr", MemAddr, 32'h40);
        check("abort_valid", 32'(InstrValid), 0);
        check("abort_valc", ValC, 32'h0);
        wait_valid("mrmovl", n);
        check("mrmovl_cycles", n, 6);
        check_instr("mrmovl", 4'h5, 4'h0, 4'h6, 4'h7, 32'h01020304, 32'h46, 32'h40);

        // Redirect coinciding with a transfer.
`ifdef FETCH_COUNT_EN
        cnt0 = InstrCount;
`endif
        redirect_to(32'h60);
        check("xfer_redir_addr", MemAddr, 32'h60);
        check("xfer_redir_valid", 32'(InstrValid), 0);
`ifdef FETCH_COUNT_EN
        check("xfer_redir_count", InstrCount, cnt0 + 32'd1);
`endif

        // Reset while holding an instruction in the output stage.
        InstrReady = 1'b0;
        wait_valid("rrmovl", n);
        check("rrmovl_cycles", n, 2);
        check("rrmovl_ra", 32'(Ra), 4);
        check("rrmovl_rb", 32'(Rb), 5);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_reset("reset_in_out");
        InstrReady = 1'b1;

        // Vector table: one instruction of each kind, full-rate memory.
        vec[0]  = '{48'h00,             1, 4'h0, 4'h0, 4'hF, 4'hF, 32'h0,        1'b0};
        vec[1]  = '{48'h10,             1, 4'h1, 4'h0, 4'hF, 4'hF, 32'h0,        1'b0};
        vec[2]  = '{48'h4520,           2, 4'h2, 4'h0, 4'h4, 4'h5, 32'h0,        1'b0};
        vec[3]  = '{48'h9A23,           2, 4'h2, 4'h3, 4'h9, 4'hA, 32'h0,        1'b0};
        vec[4]  = '{48'hDDCCBBAAF230,   6, 4'h3, 4'h0, 4'hF, 4'h2, 32'hDDCCBBAA, 1'b0};
        vec[5]  = '{48'h800000103540,   6, 4'h4, 4'h0, 4'h3, 4'h5, 32'h80000010, 1'b0};
        vec[6]  = '{48'hFFFFFFFF0150,   6, 4'h5, 4'h0, 4'h0, 4'h1, 32'hFFFFFFFF, 1'b0};
        vec[7]  = '{48'hAB61,           2, 4'h6, 4'h1, 4'hA, 4'hB, 32'h0,        1'b0};
        vec[8]  = '{48'h1122334472,     5, 4'h7, 4'h2, 4'hF, 4'hF, 32'h11223344, 1'b0};
        vec[9]  = '{48'hDEADBEEF80,     5, 4'h8, 4'h0, 4'hF, 4'hF, 32'hDEADBEEF, 1'b0};
        vec[10] = '{48'h90,             1, 4'h9, 4'h0, 4'hF, 4'hF, 32'h0,        1'b0};
        vec[11] = '{48'h3FA0,           2, 4'hA, 4'h0, 4'h3, 4'hF, 32'h0,        1'b0};
        vec[12] = '{48'h4FB0,           2, 4'hB, 4'h0, 4'h4, 4'hF, 32'h0,        1'b0};
        vec[13] = '{48'hD5,             1, 4'hD, 4'h5, 4'hF, 4'hF, 32'h0,        1'b1};
        vec[14] = '{48'hF0,             1, 4'hF, 4'h0, 4'hF, 4'hF, 32'h0,        1'b1};
        vec[15] = '{48'hC1,             1, 4'hC, 4'h1, 4'hF, 4'hF, 32'h0,        1'b1};
        for (int unsigned i = 0; i < 16; i++) begin
            base = 32'h1000 + 32'(16 * i);
            put(base, vec[i].bytes, vec[i].len);
            redirect_to(base);
            wait_valid("vec", n);
            check("vec_cycles", n, vec[i].len);
            check_instr("vec", vec[i].icode, vec[i].ifun, vec[i].ra, vec[i].rb, vec[i].valc,
                        base + vec[i].len, base);
            check("vec_err", 32'(ErrInvalid), 32'(vec[i].err));
            step();
            if (vec[i].icode == 4'h0 || vec[i].err) begin
                check("vec_halted", 32'(Halted), 1);
                check("vec_halt_memread", 32'(MemRead), 0);
            end else begin
                check("vec_next_addr", MemAddr, base + vec[i].len);
                check("vec_next_memread", 32'(MemRead), 1);
            end
        end

        // Random program near the top of the address space, random stalls and backpressure.
        base = $urandom | 32'hFFFF_FF00;
        build_random(base, 60);
        mv_mode = 2;
        redirect_to(base);
`ifdef FETCH_COUNT_EN
        cnt0 = InstrCount;
`endif
        cyc = 0;
        ntr = 0;
        while (exp_q.size() > 0 && cyc < 20000) begin
            if (InstrValid) check("rand_hold_memread", 32'(MemRead), 0);
            InstrReady = 1'($urandom_range(0, 1));
            if (InstrValid && InstrReady) begin
                instr_t e;
                e = exp_q.pop_front();
                check_instr("rand", e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.pc);
                check("rand_err", 32'(ErrInvalid), 0);
                ntr++;
            end
            step();
            cyc++;
        end
        check("rand_drained", exp_q.size(), 0);
`ifdef FETCH_COUNT_EN
        check("rand_count", InstrCount - cnt0, ntr);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/y86_fetch.md
# y86_fetch

Byte-serial instruction fetch stage for the Y86 core. It reads instruction bytes one at a time from the instruction memory port and assembles each instruction into its fields: icode/ifun, rA/rB, valC and valP. It presents the result to decode through a valid/ready handshake. Decode uses Ra/Rb directly as the read-port selectors of the architecture register file, and uses Icode/Ifun for branch-condition evaluation.

## Interface
- RESET_PC, 32'h0, PC loaded on reset
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high; clock Clock
- MemRead  out  1  byte read request
- MemAddr  out  32  address of requested byte
- MemData  in  8  returned byte; sampled when MemRead & MemValid
- MemValid  in  1  byte returned this cycle; may stall indefinitely
- Redirect  in  1  load RedirectPC and abort the current fetch
- RedirectPC  in  32  new fetch PC
- InstrValid  out  1  assembled instruction held on outputs
- InstrReady  in  1  decode accepts; transfer when InstrValid & InstrReady
- Icode, Ifun  out  4 each  opcode byte high/low nibble
- Ra, Rb  out  4 each  register byte nibbles; 4'hF when the instruction has no register byte
- ValC  out  32  little-endian constant; 0 when absent
- ValP  out  32  InstrPC + instruction length, modulo 2^32
- InstrPC  out  32  address of the opcode byte
- ErrInvalid  out  1  presented icode is invalid (> 4'hB)
- Halted  out  1  fetch stopped after halt or invalid instruction

## Operation
- States: S_OP, S_REG, S_CONST (byte counter 0..3), S_OUT, S_STOP.
- MemRead = 1 in S_OP, S_REG and S_CONST; 0 otherwise. MemAddr = fetch pointer. Each state advances only on MemValid.
- Register byte present for icode 2,3,4,5,6,A,B. valC present for icode 3,4,5 (after the register byte) and for 7,8 (directly after the opcode).
- Instruction lengths: 0,1,9 → 1 byte; 2,6,A,B → 2 bytes; 7,8 → 5 bytes; 3,4,5 → 6 bytes.
- S_OP: latch Icode/Ifun and InstrPC. Next state is S_REG, S_CONST or S_OUT depending on the icode. An invalid icode goes to S_OUT with ErrInvalid=1 and ValP=InstrPC+1.
- S_CONST stores byte k in ValC[8k+7:8k].
- S_OUT: InstrValid=1 and all outputs held stable until transfer. On transfer: icode 0 or invalid → S_STOP (Halted=1); otherwise → S_OP with the fetch pointer set to ValP.
- S_STOP: no memory requests. Only Redirect or Reset leaves it.
- Redirect has priority over everything except Reset:
  - Next state is S_OP, fetch pointer = RedirectPC, InstrValid=0, Halted=0, ErrInvalid=0, ValC=0.
  - A partially assembled instruction is discarded.
  - If a transfer occurs in the same cycle, the transfer counts and the redirect still applies.
- Reset mid-fetch or mid-handshake discards everything.

## Timing
- After Reset: state S_OP, MemRead=1, MemAddr=RESET_PC, InstrValid=0, Halted=0, ErrInvalid=0, Icode=Ifun=0, Ra=Rb=4'hF, ValC=ValP=InstrPC=0, InstrCount=0.
- With MemValid held high, an N-byte instruction takes N fetch cycles. InstrValid rises in the following cycle.
- The next opcode fetch starts the cycle after transfer, so throughput is N+1 cycles per instruction.
- Stall cycles (MemValid=0) hold the state and MemAddr unchanged.
- The fetch pointer wraps from 32'hFFFFFFFF to 0.
- All outputs except MemRead/MemAddr are registered.

## Configuration
- FETCH_COUNT_EN defined: adds output InstrCount [31:0]. Reset value 0; increments by 1 on each transfer (including halt and invalid instructions); wraps at 2^32; unaffected by Redirect.
- FETCH_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- irmovl: bytes 30 F0 78 56 34 12 at 0, MemValid=1, InstrReady=1 → InstrValid in cycle 7 with Icode=3, Ifun=0, Ra=F, Rb=0, ValC=0x12345678, ValP=6, InstrPC=0; next MemAddr=6.
- Back-to-back instructions: addl 60 01 at 6, then halt 00 → first ValP=8; second Icode=0, ValP=9; Halted=1 the cycle after transfer; MemRead stays 0.
- Backpressure and stalls: jne 74 00 01 00 00 with MemValid toggling every cycle and InstrReady=0 for 5 cycles → outputs stable with Ifun=4, ValC=0x100, Ra=Rb=F; MemRead=0 while held.
- Invalid opcode: byte C0 → ErrInvalid=1, ValP=InstrPC+1, then Halted=1. Redirect to 0x20 → Halted=0, MemAddr=0x20 next cycle.
- Abort: Redirect to 0x40 asserted during the third byte of an rmmovl → no InstrValid for the aborted instruction; MemAddr=0x40; the following instruction decodes correctly. Same test with Redirect coinciding with a transfer → the transfer counts (InstrCount+1 with FETCH_COUNT_EN).
- Wrap and reset: RESET_PC=32'hFFFFFFFF with a 2-byte instruction → second byte read from 0, ValP=1. Reset asserted while in S_OUT → state returns to the reset values listed under Timing.
